// File: rtl/pe_psum_tx_pkg.sv
// Shared types for the PE partial-sum transmit channel into psum_buffer.
// Holds the packet layout, the operation modes and the transmitter FSM states.
package pe_psum_tx_pkg;

   localparam int PSUM_W = 16;

   typedef enum logic {
      MODE_FULL = 1'b0,
      MODE_HALF = 1'b1
   } OP_MODE;

   typedef struct packed {
      logic              valid;
      logic              last;
      logic [PSUM_W-1:0] data;
   } PSUM_PACKET;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_DONE = 2'd2
   } tx_state_e;

   // Packets per convolution for a given mode; a half row sends ROW_LEN/2.
   function automatic int conv_len(input OP_MODE mode, input int row_len);
      return (mode == MODE_FULL) ? row_len : row_len / 2;
   endfunction

endpackage

// File: rtl/pe_psum_tx_if.sv
// Partial-sum channel: MAC write side into the FIFO and packet side toward psum_buffer.
// psum_out is offered while valid=1 and held stable until psum_buffer_ack=1 at a rising edge.
interface pe_psum_tx_if;
   import pe_psum_tx_pkg::*;

   logic              psum_wr_en;
   logic [PSUM_W-1:0] psum_wr_data;
   logic              psum_full;
   PSUM_PACKET        psum_out;
   logic              psum_buffer_ack;

   modport slave (
      input  psum_wr_en,
      input  psum_wr_data,
      input  psum_buffer_ack,
      output psum_full,
      output psum_out
   );

   modport master (
      output psum_wr_en,
      output psum_wr_data,
      output psum_buffer_ack,
      input  psum_full,
      input  psum_out
   );

endinterface

// File: rtl/pe_psum_tx_fifo.sv
// Synchronous FIFO for partial sums with registered full flag and sticky overflow.
// The head entry is presented combinationally on o_rd_data whenever the FIFO is non-empty.
module psum_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_wr_en,
   input  logic [W-1:0]               i_wr_data,
   input  logic                       i_rd_en,
   output logic [W-1:0]               o_rd_data,
   output logic                       o_empty,
   output logic                       o_full,
   output logic                       o_overflow,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic [CW-1:0] w_count_nxt;
   logic          r_full;
   logic          r_overflow;
   logic          w_push;
   logic          w_pop;
   logic          w_empty;

   // Writes are judged against the registered full flag, so a same-cycle pop never rescues one.
   assign w_empty = (r_count == '0);
   assign w_push  = i_wr_en && !r_full;
   assign w_pop   = i_rd_en && !w_empty;

   always_comb begin
      w_count_nxt = r_count;
      if (w_push && !w_pop) begin
         w_count_nxt = r_count + CW'(1);
      end else if (!w_push && w_pop) begin
         w_count_nxt = r_count - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_full     <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == CW'(DEPTH));
         if (i_wr_en && r_full) r_overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
   end

   assign o_rd_data  = r_mem[r_rd_ptr];
   assign o_empty    = w_empty;
   assign o_full     = r_full;
   assign o_overflow = r_overflow;
   assign o_count    = r_count;

endmodule

// File: rtl/pe_psum_tx.sv
// PE-row partial-sum transmitter: queues MAC results and streams one packet lane to psum_buffer,
// tagging the final packet of each convolution and pulsing conv_done once it is accepted.
module pe_psum_tx
   import pe_psum_tx_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int ROW_LEN    = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start_conv,
   input  OP_MODE                        mode_in,
   pe_psum_tx_if.slave                   bus,
   output logic                          conv_done,
   output logic                          overflow,
   output tx_state_e                     o_dbg_state,
   output logic [$clog2(FIFO_DEPTH):0]   o_dbg_occupancy
);

   localparam int CW = $clog2(ROW_LEN) + 1;

   tx_state_e         r_state;
   tx_state_e         w_state_nxt;
   PSUM_PACKET        r_out;
   PSUM_PACKET        w_out_nxt;
   logic [CW-1:0]     r_sent_cnt;
   logic [CW-1:0]     w_sent_nxt;
   logic [CW-1:0]     r_total;
   logic [CW-1:0]     w_total_nxt;
   logic              w_pop;
   logic              w_empty;
   logic              w_full;
   logic [PSUM_W-1:0] w_head;

   psum_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (PSUM_W)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_wr_en    (bus.psum_wr_en),
      .i_wr_data  (bus.psum_wr_data),
      .i_rd_en    (w_pop),
      .o_rd_data  (w_head),
      .o_empty    (w_empty),
      .o_full     (w_full),
      .o_overflow (overflow),
      .o_count    (o_dbg_occupancy)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_out      <= '0;
         r_sent_cnt <= '0;
         r_total    <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_out      <= w_out_nxt;
         r_sent_cnt <= w_sent_nxt;
         r_total    <= w_total_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_out_nxt   = r_out;
      w_sent_nxt  = r_sent_cnt;
      w_total_nxt = r_total;
      w_pop       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start_conv) begin
               w_total_nxt = CW'(conv_len(mode_in, ROW_LEN));
               w_sent_nxt  = '0;
               w_state_nxt = ST_SEND;
            end
         end
         ST_SEND: begin
            if (r_out.valid && bus.psum_buffer_ack) begin
               w_sent_nxt = r_sent_cnt + CW'(1);
               w_out_nxt  = '0;
               if (r_out.last) begin
                  w_state_nxt = ST_DONE;
               end else if (!w_empty) begin
                  // Back-to-back: refill the output register on the same edge as the accept.
                  w_pop           = 1'b1;
                  w_out_nxt.valid = 1'b1;
                  w_out_nxt.last  = (w_sent_nxt == r_total - CW'(1));
                  w_out_nxt.data  = w_head;
               end
            end else if (!r_out.valid && !w_empty) begin
               w_pop           = 1'b1;
               w_out_nxt.valid = 1'b1;
               w_out_nxt.last  = (r_sent_cnt == r_total - CW'(1));
               w_out_nxt.data  = w_head;
            end
         end
         ST_DONE: begin
            w_out_nxt   = '0;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_out_nxt   = '0;
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign bus.psum_out  = r_out;
   assign bus.psum_full = w_full;
   assign conv_done     = (r_state == ST_DONE);
   assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_pe_psum_tx.sv
// Bench for pe_psum_tx: a depth-4 instance for most scenarios and a depth-8 instance for the
// full-row prefetch; accepted packets are scored against expected queues with an independent last-tag model.
module tb_pe_psum_tx;
   import pe_psum_tx_pkg::*;

   localparam int ROW_LEN = 8;

   logic      clk = 1'b0;
   logic      rst_n = 1'b0;
   logic      start4, start8;
   OP_MODE    mode4, mode8;
   logic      done4, done8, ovf4, ovf8;
   tx_state_e st4, st8;
   logic [2:0] occ4;
   logic [3:0] occ8;

   pe_psum_tx_if bus4 ();
   pe_psum_tx_if bus8 ();

   int errors = 0;
   int checks = 0;
   logic [PSUM_W-1:0] exp_q[$];
   logic [PSUM_W-1:0] exp8_q[$];
   int pkt_idx4, pkt_idx8, exp_total4, acc4, acc8, done_cnt4, done_cnt8;
   logic [PSUM_W-1:0] mon_e4, mon_e8;
   logic mon_l4, mon_l8;

   always #5 clk = ~clk;

   pe_psum_tx #(.FIFO_DEPTH(4), .ROW_LEN(ROW_LEN)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start_conv(start4), .mode_in(mode4), .bus(bus4.slave),
      .conv_done(done4), .overflow(ovf4), .o_dbg_state(st4), .o_dbg_occupancy(occ4)
   );

   pe_psum_tx #(.FIFO_DEPTH(8), .ROW_LEN(ROW_LEN)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start_conv(start8), .mode_in(mode8), .bus(bus8.slave),
      .conv_done(done8), .overflow(ovf8), .o_dbg_state(st8), .o_dbg_occupancy(occ8)
   );

   // Scoreboard: a handshake seen at the negedge completes on the following rising edge.
   always @(negedge clk) begin
      if (rst_n && bus4.psum_out.valid && bus4.psum_buffer_ack) begin
         checks++;
         mon_l4 = (pkt_idx4 == exp_total4 - 1);
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb4_unexpected: got data=%h, required no packet", bus4.psum_out.data);
         end else begin
            mon_e4 = exp_q.pop_front();
            if ({bus4.psum_out.last, bus4.psum_out.data} !== {mon_l4, mon_e4}) begin
               errors++;
               $display("FAIL sb4_packet: got last=%b data=%h, required last=%b data=%h",
                        bus4.psum_out.last, bus4.psum_out.data, mon_l4, mon_e4);
            end
         end
         pkt_idx4++;
         acc4++;
      end
      if (rst_n && bus8.psum_out.valid && bus8.psum_buffer_ack) begin
         checks++;
         mon_l8 = (pkt_idx8 == ROW_LEN - 1);
         if (exp8_q.size() == 0) begin
            errors++;
            $display("FAIL sb8_unexpected: got data=%h, required no packet", bus8.psum_out.data);
         end else begin
            mon_e8 = exp8_q.pop_front();
            if ({bus8.psum_out.last, bus8.psum_out.data} !== {mon_l8, mon_e8}) begin
               errors++;
               $display("FAIL sb8_packet: got last=%b data=%h, required last=%b data=%h",
                        bus8.psum_out.last, bus8.psum_out.data, mon_l8, mon_e8);
            end
         end
         pkt_idx8++;
         acc8++;
      end
      if (rst_n && done4) done_cnt4++;
      if (rst_n && done8) done_cnt8++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      start4 = 1'b0; start8 = 1'b0;
      mode4 = MODE_FULL; mode8 = MODE_FULL;
      bus4.psum_wr_en = 1'b0; bus4.psum_wr_data = '0; bus4.psum_buffer_ack = 1'b0;
      bus8.psum_wr_en = 1'b0; bus8.psum_wr_data = '0; bus8.psum_buffer_ack = 1'b0;
      exp_q.delete(); exp8_q.delete();
      pkt_idx4 = 0; pkt_idx8 = 0; acc4 = 0; acc8 = 0; done_cnt4 = 0; done_cnt8 = 0;
      exp_total4 = ROW_LEN;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      step();
   endtask

   task automatic wr4(input logic [PSUM_W-1:0] d, input bit expect_accept);
      bus4.psum_wr_en = 1'b1;
      bus4.psum_wr_data = d;
      if (expect_accept) exp_q.push_back(d);
      step();
      bus4.psum_wr_en = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({bus4.psum_out, bus4.psum_full, done4, ovf4, occ4} !== '0 || st4 !== ST_IDLE) begin
         errors++;
         $display("FAIL reset4: got out=%h full=%b done=%b ovf=%b occ=%0d st=%0d, required all zero/IDLE",
                  bus4.psum_out, bus4.psum_full, done4, ovf4, occ4, st4);
      end
      checks++;
      if ({bus8.psum_out, bus8.psum_full, done8, ovf8, occ8} !== '0 || st8 !== ST_IDLE) begin
         errors++;
         $display("FAIL reset8: got out=%h full=%b done=%b ovf=%b occ=%0d st=%0d, required all zero/IDLE",
                  bus8.psum_out, bus8.psum_full, done8, ovf8, occ8, st8);
      end
   endtask

   task automatic test_prefetch_full();
      int nvalid, first_i, last_i, done_i;
      do_reset();
      for (int i = 1; i <= 8; i++) begin
         bus8.psum_wr_en = 1'b1;
         bus8.psum_wr_data = PSUM_W'(i);
         exp8_q.push_back(PSUM_W'(i));
         step();
      end
      bus8.psum_wr_en = 1'b0;
      checks++;
      if (bus8.psum_full !== 1'b1 || occ8 !== 4'd8) begin
         errors++;
         $display("FAIL prefetch_full: got full=%b occ=%0d, required full=1 occ=8", bus8.psum_full, occ8);
      end
      pkt_idx8 = 0;
      start8 = 1'b1; mode8 = MODE_FULL; bus8.psum_buffer_ack = 1'b1;
      step();
      start8 = 1'b0;
      nvalid = 0; first_i = -1; last_i = -1; done_i = -1;
      for (int i = 0; i < 20; i++) begin
         if (bus8.psum_out.valid) begin
            nvalid++;
            if (first_i < 0) first_i = i;
            last_i = i;
         end
         if (done8) done_i = i;
         step();
      end
      bus8.psum_buffer_ack = 1'b0;
      checks++;
      if (nvalid != 8 || last_i - first_i != 7) begin
         errors++;
         $display("FAIL prefetch_burst: got %0d valid cycles span %0d, required 8 consecutive", nvalid, last_i - first_i + 1);
      end
      checks++;
      if (done_i != last_i + 1 || done_cnt8 != 1) begin
         errors++;
         $display("FAIL prefetch_done: got done at %0d (pulses %0d), required at %0d (1 pulse)", done_i, done_cnt8, last_i + 1);
      end
      checks++;
      if (acc8 != 8 || exp8_q.size() != 0 || st8 !== ST_IDLE) begin
         errors++;
         $display("FAIL prefetch_drain: got acc=%0d left=%0d st=%0d, required acc=8 left=0 IDLE", acc8, exp8_q.size(), st8);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         wr4(PSUM_W'(16'h1000 + i), i < 4);
         if (i == 2) begin
            checks++;
            if (bus4.psum_full !== 1'b0 || occ4 !== 3'd3) begin
               errors++;
               $display("FAIL ovf_three: got full=%b occ=%0d, required full=0 occ=3", bus4.psum_full, occ4);
            end
         end
         if (i == 3) begin
            checks++;
            if (bus4.psum_full !== 1'b1 || occ4 !== 3'd4 || ovf4 !== 1'b0) begin
               errors++;
               $display("FAIL ovf_four: got full=%b occ=%0d ovf=%b, required full=1 occ=4 ovf=0", bus4.psum_full, occ4, ovf4);
            end
         end
      end
      checks++;
      if (ovf4 !== 1'b1 || occ4 !== 3'd4 || bus4.psum_full !== 1'b1) begin
         errors++;
         $display("FAIL ovf_drop: got ovf=%b occ=%0d full=%b, required ovf=1 occ=4 full=1", ovf4, occ4, bus4.psum_full);
      end
   endtask

   task automatic test_push_pop();
      int n;
      do_reset();
      for (int i = 0; i < 4; i++) wr4(PSUM_W'($urandom_range(0, 16'hffff)), 1'b1);
      exp_total4 = ROW_LEN; pkt_idx4 = 0;
      start4 = 1'b1; mode4 = MODE_FULL;
      step();
      start4 = 1'b0;
      step();
      checks++;
      if (occ4 !== 3'd3 || bus4.psum_out.valid !== 1'b1) begin
         errors++;
         $display("FAIL pp_first: got occ=%0d valid=%b, required occ=3 valid=1", occ4, bus4.psum_out.valid);
      end
      bus4.psum_buffer_ack = 1'b1;
      wr4(PSUM_W'($urandom_range(0, 16'hffff)), 1'b1);
      bus4.psum_buffer_ack = 1'b0;
      checks++;
      if (occ4 !== 3'd3) begin
         errors++;
         $display("FAIL pp_same: got occ=%0d, required occ=3", occ4);
      end
      wr4(PSUM_W'($urandom_range(0, 16'hffff)), 1'b1);
      checks++;
      if (occ4 !== 3'd4 || bus4.psum_full !== 1'b1 || ovf4 !== 1'b0) begin
         errors++;
         $display("FAIL pp_fill: got occ=%0d full=%b ovf=%b, required occ=4 full=1 ovf=0", occ4, bus4.psum_full, ovf4);
      end
      bus4.psum_buffer_ack = 1'b1;
      wr4(16'hdead, 1'b0);
      checks++;
      if (ovf4 !== 1'b1 || occ4 !== 3'd3 || bus4.psum_full !== 1'b0) begin
         errors++;
         $display("FAIL pp_full_ack: got ovf=%b occ=%0d full=%b, required ovf=1 occ=3 full=0", ovf4, occ4, bus4.psum_full);
      end
      wr4(PSUM_W'($urandom_range(0, 16'hffff)), 1'b1);
      wr4(PSUM_W'($urandom_range(0, 16'hffff)), 1'b1);
      for (n = 0; n < 20 && !done4; n++) step();
      step();
      bus4.psum_buffer_ack = 1'b0;
      checks++;
      if (acc4 != 8 || done_cnt4 != 1 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL pp_drain: got acc=%0d done=%0d left=%0d, required acc=8 done=1 left=0", acc4, done_cnt4, exp_q.size());
      end
   endtask

   task automatic test_half_stall();
      int n;
      PSUM_PACKET held;
      do_reset();
      for (int i = 0; i < 4; i++) wr4(PSUM_W'($urandom_range(0, 16'hffff)), 1'b1);
      exp_total4 = ROW_LEN / 2; pkt_idx4 = 0;
      start4 = 1'b1; mode4 = MODE_HALF;
      step();
      start4 = 1'b0;
      for (n = 0; n < 10 && !bus4.psum_out.valid; n++) step();
      held = bus4.psum_out;
      checks++;
      if (held.valid !== 1'b1 || held.last !== 1'b0 || held.data !== exp_q[0]) begin
         errors++;
         $display("FAIL half_first: got %h, required valid=1 last=0 data=%h", held, exp_q[0]);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (bus4.psum_out !== held) begin
            errors++;
            $display("FAIL half_hold: got %h, required %h", bus4.psum_out, held);
         end
      end
      bus4.psum_buffer_ack = 1'b1;
      for (n = 0; n < 20 && !done4; n++) step();
      checks++;
      if (done4 !== 1'b1 || bus4.psum_out.valid !== 1'b0) begin
         errors++;
         $display("FAIL half_done: got done=%b valid=%b, required done=1 valid=0", done4, bus4.psum_out.valid);
      end
      step();
      bus4.psum_buffer_ack = 1'b0;
      checks++;
      if (done4 !== 1'b0 || st4 !== ST_IDLE || acc4 != 4 || done_cnt4 != 1 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL half_end: got done=%b st=%0d acc=%0d pulses=%0d, required done=0 IDLE acc=4 pulses=1",
                  done4, st4, acc4, done_cnt4);
      end
   endtask

   task automatic test_ignore_start();
      int n;
      do_reset();
      for (int i = 0; i < 4; i++) wr4(PSUM_W'($urandom_range(0, 16'hffff)), 1'b1);
      exp_total4 = ROW_LEN; pkt_idx4 = 0;
      start4 = 1'b1; mode4 = MODE_FULL; bus4.psum_buffer_ack = 1'b1;
      step();
      start4 = 1'b0;
      step();
      step();
      start4 = 1'b1; mode4 = MODE_HALF;
      step();
      start4 = 1'b0;
      for (int i = 0; i < 4; i++) wr4(PSUM_W'($urandom_range(0, 16'hffff)), 1'b1);
      for (n = 0; n < 30 && !done4; n++) step();
      checks++;
      if (done4 !== 1'b1) begin
         errors++;
         $display("FAIL ign_timeout: got done=%b acc=%0d, required done=1 within 30 cycles", done4, acc4);
      end
      start4 = 1'b1; mode4 = MODE_FULL;
      step();
      start4 = 1'b0;
      bus4.psum_buffer_ack = 1'b0;
      checks++;
      if (st4 !== ST_IDLE) begin
         errors++;
         $display("FAIL ign_done_start: got st=%0d, required IDLE", st4);
      end
      repeat (5) step();
      checks++;
      if (done_cnt4 != 1 || acc4 != 8 || st4 !== ST_IDLE || bus4.psum_out.valid !== 1'b0) begin
         errors++;
         $display("FAIL ign_end: got pulses=%0d acc=%0d st=%0d valid=%b, required 1 8 IDLE 0",
                  done_cnt4, acc4, st4, bus4.psum_out.valid);
      end
   endtask

   task automatic test_reset_mid_send();
      int n;
      do_reset();
      for (int i = 0; i < 3; i++) wr4(PSUM_W'($urandom_range(0, 16'hffff)), 1'b1);
      exp_total4 = ROW_LEN; pkt_idx4 = 0;
      start4 = 1'b1; mode4 = MODE_FULL;
      step();
      start4 = 1'b0;
      for (n = 0; n < 10 && !bus4.psum_out.valid; n++) step();
      checks++;
      if (bus4.psum_out.valid !== 1'b1 || occ4 !== 3'd2 || st4 !== ST_SEND) begin
         errors++;
         $display("FAIL rst_pre: got valid=%b occ=%0d st=%0d, required valid=1 occ=2 SEND", bus4.psum_out.valid, occ4, st4);
      end
      rst_n = 1'b0;
      step();
      exp_q.delete();
      checks++;
      if (bus4.psum_out !== '0 || bus4.psum_full !== 1'b0 || st4 !== ST_IDLE || occ4 !== 3'd0) begin
         errors++;
         $display("FAIL rst_mid: got out=%h full=%b st=%0d occ=%0d, required 0 0 IDLE 0", bus4.psum_out, bus4.psum_full, st4, occ4);
      end
      rst_n = 1'b1;
      step();
      checks++;
      if (bus4.psum_out.valid !== 1'b0 || st4 !== ST_IDLE || occ4 !== 3'd0) begin
         errors++;
         $display("FAIL rst_after: got valid=%b st=%0d occ=%0d, required 0 IDLE 0", bus4.psum_out.valid, st4, occ4);
      end
   endtask

   initial begin
      test_reset();
      test_prefetch_full();
      test_overflow();
      test_push_pop();
      test_half_stall();
      test_ignore_start();
      test_reset_mid_send();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/pe_psum_tx.md
Name: pe_psum_tx

Overview:
- PE-side transmitter for the partial-sum channel into psum_buffer; one instance per PE row, seven in the array.
- Queues partial sums produced by the PE MAC datapath in a small FIFO.
- Drives one PSUM_PACKET lane toward psum_buffer with a valid/ack handshake.
- Counts packets per convolution, tags the final packet `last` and pulses conv_done when it is accepted.

Parameters:
- FIFO_DEPTH, 4, FIFO entries; power of two, at least 2.
- ROW_LEN, 8, packets per convolution in MODE_FULL; must be even. MODE_HALF uses ROW_LEN/2.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start_conv  input  1  single-cycle pulse that begins a convolution.
- mode_in  input  OP_MODE  operation mode; sampled only on an accepted start_conv.
- psum_wr_en  input  1  MAC datapath write strobe.
- psum_wr_data  input  PSUM_W  signed partial sum.
- psum_full  output  1  FIFO full.
- psum_out  output  PSUM_PACKET  packet to psum_buffer: fields valid, last, data[PSUM_W-1:0].
- psum_buffer_ack  input  1  psum_buffer accepted the current packet.
- conv_done  output  1  one-cycle pulse after the final packet is accepted.
- overflow  output  1  sticky flag: a write arrived while full.

Behaviour:
- Reset (asynchronous, rst_n low):
  - FIFO empty, pointers 0, FSM in IDLE.
  - psum_out all zero; psum_full=0, conv_done=0, overflow=0; sent_cnt=0.
- FIFO:
  - A write is accepted when psum_wr_en=1 and psum_full=0, in any FSM state (prefetch before start is allowed).
  - A write while full is dropped and sets overflow. This holds even if a pop happens in the same cycle.
  - Simultaneous push and pop when not full leaves the occupancy unchanged.
  - Pointers wrap modulo FIFO_DEPTH. An extra occupancy bit distinguishes full from empty.
  - psum_full is registered and equals occupancy==FIFO_DEPTH.
- FSM states: IDLE, SEND, DONE.
  - IDLE: on start_conv=1, latch total = (mode_in==MODE_FULL) ? ROW_LEN : ROW_LEN/2, clear sent_cnt, go to SEND.
  - SEND: start_conv is ignored. Go to DONE on the cycle the packet with last=1 is acked.
  - DONE: conv_done=1 for exactly this cycle, psum_out.valid=0, then go to IDLE.
  - A start_conv arriving in DONE is ignored.
- Output register, SEND only:
  - If psum_out.valid=0 and the FIFO is non-empty, pop the head into psum_out next cycle with valid=1 and last=(sent_cnt==total-1).
  - While valid=1 and ack=0, all fields are held stable.
  - When valid=1 and ack=1 at a rising edge, increment sent_cnt. If this was not the last packet and the FIFO is non-empty, load the next head in the same edge (back-to-back, one packet per cycle). Otherwise valid drops to 0.
  - ack while valid=0 is ignored.
  - Latency: a write into an empty FIFO during SEND makes valid=1 two cycles later.
- After the last packet, remaining FIFO contents stay queued for the next convolution.
- data is passed through unmodified; no arithmetic on the value. sent_cnt is $clog2(ROW_LEN)+1 bits wide.
- overflow clears only on reset.

Decomposition:
- Shared package (existing team package, extended):
  - OP_MODE enum {MODE_FULL, MODE_HALF}.
  - PSUM_W=16.
  - PSUM_PACKET packed struct {valid, last, data[PSUM_W-1:0]}.
- One sub-module, psum_fifo: parameterised synchronous FIFO with full/empty/overflow outputs.
- The FSM, counter and output register live in pe_psum_tx.

Test Plan:
- Reset mid-SEND, with valid=1 and 2 entries queued → next cycle psum_out=0, psum_full=0, FSM IDLE; the queued data is discarded.
- Prefetch 8 writes (0x0001..0x0008) with FIFO_DEPTH=8, then start_conv MODE_FULL with ack held high → 8 consecutive valid cycles, data 1..8, last only on 0x0008, conv_done one cycle after.
- MODE_HALF, 4 writes, ack low for 3 cycles on the first packet → packet 1 held stable 3 cycles; 4 packets total; last on the 4th; conv_done pulse.
- 5 writes with FIFO_DEPTH=4 and no start → psum_full=1 after 4, 5th dropped, overflow=1, occupancy stays 4.
- Simultaneous push and pop at occupancy 3 → occupancy stays 3. Push plus ack while full → write dropped, overflow=1, occupancy becomes 3.
- start_conv pulsed mid-SEND and during DONE → ignored; sent_cnt unaffected; exactly one conv_done per accepted start.
